// File: rtl/sd_sector_seq.sv
// sd_sector_seq
// Command sequencer placed in front of the SD SPI engine. It turns host
// requests (initialise card, read N sectors, write N sectors) into the engine's
// level-sensitive request/acknowledge protocol. A multi-sector transfer is sent
// as a series of single-sector commands, and the block address goes up by one
// for each sector.
//
// Ports
//   clk, rst_n            system clock, asynchronous active-low reset
//   start_init            host: initialise card (sampled in IDLE)
//   rd_req / wr_req       host: multi-sector read / write (sampled in IDLE)
//   req_sec[31:0]         host: starting block address, captured on accept
//   req_cnt[15:0]         host: sector count, captured on accept
//   busy                  high from accept until the done pulse
//   done                  one-cycle completion pulse
//   err                   sticky error, cleared by the next accept
//   card_ready            card initialised
//   sectors_done[15:0]    sectors completed in the current/last request
//   sd_init/sd_ren/sd_wen engine requests (at most one high at a time)
//   sec[31:0]             engine block address of the current sector
//   fifo_busy             acknowledge to engine, returns it to idle
//   init_ok/rd_ok/wr_ok   engine completions (sd_ck domain, synchronised here)
//   dbg_state[2:0]        current FSM state encoding
//
// Engine handshake:
//   The sequencer raises one request (sd_init, sd_ren or sd_wen) and holds it
//   until the matching *_ok is seen high after synchronisation. It then drops
//   the request and raises fifo_busy. fifo_busy stays high for at least
//   BUSY_HOLD cycles and, for reads and writes, until *_ok is seen low again.
//   A request and fifo_busy are never high in the same cycle.
module sd_sector_seq #(
  parameter int unsigned BUSY_HOLD   = 24,
  parameter int unsigned TIMEOUT_CYC = 24'hFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_init,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [31:0] req_sec,
  input  logic [15:0] req_cnt,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        card_ready,
  output logic [15:0] sectors_done,
  output logic        sd_init,
  output logic        sd_ren,
  output logic        sd_wen,
  output logic [31:0] sec,
  output logic        fifo_busy,
  input  logic        init_ok,
  input  logic        rd_ok,
  input  logic        wr_ok,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_ACK   = 3'd4,
    S_DROP  = 3'd5,
    S_NEXT  = 3'd6,
    S_FIN   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    OP_INIT = 2'd0,
    OP_RD   = 2'd1,
    OP_WR   = 2'd2
  } op_t;

  // Counter reload values. One down-counter serves both the completion
  // timeout and the fifo_busy hold time, because the two never overlap.
  localparam logic [31:0] TMO_LOAD  = 32'(TIMEOUT_CYC - 32'd1);
  localparam logic [31:0] HOLD_LOAD = 32'(BUSY_HOLD - 32'd1);

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers. The *_ok inputs change on sd_ck edges.
  // ---------------------------------------------------------------------------
  logic init_ok_m, rd_ok_m, wr_ok_m;
  logic init_ok_s, rd_ok_s, wr_ok_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_ok_m <= 1'b0;
      rd_ok_m   <= 1'b0;
      wr_ok_m   <= 1'b0;
      init_ok_s <= 1'b0;
      rd_ok_s   <= 1'b0;
      wr_ok_s   <= 1'b0;
    end else begin
      init_ok_m <= init_ok;
      rd_ok_m   <= rd_ok;
      wr_ok_m   <= wr_ok;
      init_ok_s <= init_ok_m;
      rd_ok_s   <= rd_ok_m;
      wr_ok_s   <= wr_ok_m;
    end
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t      state, state_d;
  op_t         op, op_d;
  logic [31:0] base_sec, base_sec_d;
  logic [15:0] cnt, cnt_d;
  logic [15:0] sectors_done_d;
  logic [31:0] tmr, tmr_d;
  logic        abort, abort_d;
  logic        busy_d, done_d, err_d, card_ready_d;
  logic        sd_init_d, sd_ren_d, sd_wen_d, fifo_busy_d;
  logic [31:0] sec_d;
  logic        op_ok_s;

  // Completion flag of the read/write currently being handled.
  assign op_ok_s   = (op == OP_RD) ? rd_ok_s : wr_ok_s;
  assign dbg_state = state;

  always_comb begin
    state_d        = state;
    op_d           = op;
    base_sec_d     = base_sec;
    cnt_d          = cnt;
    sectors_done_d = sectors_done;
    tmr_d          = tmr;
    abort_d        = abort;
    busy_d         = busy;
    done_d         = 1'b0;
    err_d          = err;
    card_ready_d   = card_ready;
    sd_init_d      = sd_init;
    sd_ren_d       = sd_ren;
    sd_wen_d       = sd_wen;
    sec_d          = sec;
    fifo_busy_d    = fifo_busy;

    case (state)
      S_IDLE: begin
        if (start_init) begin
          // Initialisation always reruns, even on a card that is already ready.
          op_d           = OP_INIT;
          base_sec_d     = req_sec;
          cnt_d          = req_cnt;
          busy_d         = 1'b1;
          err_d          = 1'b0;
          abort_d        = 1'b0;
          sectors_done_d = 16'd0;
          card_ready_d   = 1'b0;
          sd_init_d      = 1'b1;
          tmr_d          = TMO_LOAD;
          state_d        = S_INIT;
        end else if (rd_req || wr_req) begin
          op_d           = rd_req ? OP_RD : OP_WR;
          base_sec_d     = req_sec;
          cnt_d          = req_cnt;
          busy_d         = 1'b1;
          err_d          = 1'b0;
          abort_d        = 1'b0;
          sectors_done_d = 16'd0;
          if (!card_ready) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else if (req_cnt == 16'd0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end

      S_INIT: begin
        if (init_ok_s) begin
          // init_ok stays high afterwards, so the acknowledge skips DROP.
          sd_init_d    = 1'b0;
          card_ready_d = 1'b1;
          fifo_busy_d  = 1'b1;
          tmr_d        = HOLD_LOAD;
          state_d      = S_ACK;
        end else if (tmr == 32'd0) begin
          sd_init_d   = 1'b0;
          err_d       = 1'b1;
          abort_d     = 1'b1;
          fifo_busy_d = 1'b1;
          tmr_d       = HOLD_LOAD;
          state_d     = S_ACK;
        end else begin
          tmr_d = tmr - 32'd1;
        end
      end

      S_ISSUE: begin
        // The address wraps modulo 2^32.
        sec_d    = base_sec + {16'd0, sectors_done};
        sd_ren_d = (op == OP_RD);
        sd_wen_d = (op == OP_WR);
        tmr_d    = TMO_LOAD;
        state_d  = S_WAIT;
      end

      S_WAIT: begin
        if (op_ok_s) begin
          sd_ren_d    = 1'b0;
          sd_wen_d    = 1'b0;
          fifo_busy_d = 1'b1;
          tmr_d       = HOLD_LOAD;
          state_d     = S_ACK;
        end else if (tmr == 32'd0) begin
          // Stalled engine: abort, but still send one acknowledge pulse.
          sd_ren_d    = 1'b0;
          sd_wen_d    = 1'b0;
          err_d       = 1'b1;
          abort_d     = 1'b1;
          fifo_busy_d = 1'b1;
          tmr_d       = HOLD_LOAD;
          state_d     = S_ACK;
        end else begin
          tmr_d = tmr - 32'd1;
        end
      end

      S_ACK: begin
        if (tmr == 32'd0) begin
          if (op == OP_INIT || abort) begin
            fifo_busy_d = 1'b0;
            state_d     = S_FIN;
          end else begin
            // fifo_busy stays high in DROP until the ok line is seen low.
            tmr_d   = TMO_LOAD;
            state_d = S_DROP;
          end
        end else begin
          tmr_d = tmr - 32'd1;
        end
      end

      S_DROP: begin
        if (!op_ok_s) begin
          fifo_busy_d    = 1'b0;
          sectors_done_d = sectors_done + 16'd1;
          state_d        = S_NEXT;
        end else if (tmr == 32'd0) begin
          err_d   = 1'b1;
          abort_d = 1'b1;
          tmr_d   = HOLD_LOAD;
          state_d = S_ACK;
        end else begin
          tmr_d = tmr - 32'd1;
        end
      end

      S_NEXT: begin
        if (sectors_done == cnt) begin
          state_d = S_FIN;
        end else begin
          state_d = S_ISSUE;
        end
      end

      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      op           <= OP_INIT;
      base_sec     <= 32'd0;
      cnt          <= 16'd0;
      sectors_done <= 16'd0;
      tmr          <= 32'd0;
      abort        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      card_ready   <= 1'b0;
      sd_init      <= 1'b0;
      sd_ren       <= 1'b0;
      sd_wen       <= 1'b0;
      sec          <= 32'd0;
      fifo_busy    <= 1'b0;
    end else begin
      state        <= state_d;
      op           <= op_d;
      base_sec     <= base_sec_d;
      cnt          <= cnt_d;
      sectors_done <= sectors_done_d;
      tmr          <= tmr_d;
      abort        <= abort_d;
      busy         <= busy_d;
      done         <= done_d;
      err          <= err_d;
      card_ready   <= card_ready_d;
      sd_init      <= sd_init_d;
      sd_ren       <= sd_ren_d;
      sd_wen       <= sd_wen_d;
      sec          <= sec_d;
      fifo_busy    <= fifo_busy_d;
    end
  end

endmodule

// File: tb/tb_sd_sector_seq.sv
// Directed testbench for sd_sector_seq. The bench itself plays the SD engine
// by hand. Expected values are worked out from the cycle behaviour: the
// 2-flop ok synchroniser plus one FSM edge, BUSY_HOLD = 24 and
// TIMEOUT_CYC = 1000.
module tb_sd_sector_seq;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_init = 1'b0, rd_req = 1'b0, wr_req = 1'b0;
  logic [31:0] req_sec = 32'd0;
  logic [15:0] req_cnt = 16'd0;
  logic        init_ok = 1'b0, rd_ok = 1'b0, wr_ok = 1'b0;
  logic        busy, done, err, card_ready, sd_init, sd_ren, sd_wen, fifo_busy;
  logic [15:0] sectors_done;
  logic [31:0] sec;
  logic [2:0]  dbg_state;

  sd_sector_seq #(.BUSY_HOLD(24), .TIMEOUT_CYC(1000)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_init(start_init), .rd_req(rd_req), .wr_req(wr_req),
    .req_sec(req_sec), .req_cnt(req_cnt),
    .busy(busy), .done(done), .err(err), .card_ready(card_ready),
    .sectors_done(sectors_done),
    .sd_init(sd_init), .sd_ren(sd_ren), .sd_wen(sd_wen), .sec(sec),
    .fifo_busy(fifo_busy),
    .init_ok(init_ok), .rd_ok(rd_ok), .wr_ok(wr_ok),
    .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int ren_rises = 0, wen_rises = 0, init_rises = 0, done_cnt = 0;
  int overlap_cnt = 0, multi_cnt = 0;
  logic ren_q = 1'b0, wen_q = 1'b0, init_q = 1'b0;

  // Monitor sampling on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (sd_ren && !ren_q) begin ren_rises++; got_q.push_back(sec); end
    if (sd_wen && !wen_q) begin wen_rises++; got_q.push_back(sec); end
    if (sd_init && !init_q) init_rises++;
    if (done) done_cnt++;
    if (fifo_busy && (sd_init || sd_ren || sd_wen)) overlap_cnt++;
    if ((int'(sd_init) + int'(sd_ren) + int'(sd_wen)) > 1) multi_cnt++;
    ren_q  = sd_ren;
    wen_q  = sd_wen;
    init_q = sd_init;
  end

  // ---------------------------------------------------------------------------
  // Driver / checker tasks
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 3000) begin tick(1); n++; end
    check(tag, done, 1'b1);
  endtask

  // Plays the engine for one sector: answers the request, then releases ok.
  task automatic serve(input bit is_rd, input string tag);
    int n;
    n = 0;
    while (!(is_rd ? sd_ren : sd_wen) && n < 100) begin tick(1); n++; end
    check({tag, "_req"}, is_rd ? sd_ren : sd_wen, 1'b1);
    tick(4);
    if (is_rd) rd_ok = 1'b1; else wr_ok = 1'b1;
    tick(3);
    check({tag, "_req_drop"}, is_rd ? sd_ren : sd_wen, 1'b0);
    check({tag, "_fb_on"}, fifo_busy, 1'b1);
    tick(30);
    check({tag, "_fb_hold"}, fifo_busy, 1'b1);
    if (is_rd) rd_ok = 1'b0; else wr_ok = 1'b0;
    n = 0;
    while (fifo_busy && n < 20) begin tick(1); n++; end
    check({tag, "_fb_release_lat"}, n, 32'd3);
  endtask

  task automatic check_secs(input string tag);
    check({tag, "_sec_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({tag, "_sec"}, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    int d0, r0, w0, i0;

    tick(3);
    rst_n = 1'b1;
    tick(1);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_card_ready", card_ready, 1'b0);
    check("rst_sec", sec, 32'd0);
    check("rst_sectors_done", sectors_done, 16'd0);
    check("rst_req_lines", {sd_init, sd_ren, sd_wen, fifo_busy, done}, 5'b0);

    // Guard: read before init -> error, no engine activity
    rd_req = 1'b1; req_sec = 32'h10; req_cnt = 16'd1;
    tick(1);
    rd_req = 1'b0;
    check("guard_busy", busy, 1'b1);
    check("guard_done_early", done, 1'b0);
    tick(1);
    check("guard_done", done, 1'b1);
    check("guard_err", err, 1'b1);
    check("guard_busy_low", busy, 1'b0);
    check("guard_no_ren", ren_rises, 0);
    tick(1);
    check("guard_done_pulse", done, 1'b0);

    // Init
    start_init = 1'b1;
    tick(1);
    start_init = 1'b0;
    check("init_busy", busy, 1'b1);
    check("init_sd_init", sd_init, 1'b1);
    check("init_err_cleared", err, 1'b0);
    tick(500);
    init_ok = 1'b1;
    tick(2);
    check("init_hold", sd_init, 1'b1);
    tick(1);
    check("init_drop", sd_init, 1'b0);
    check("init_card_ready", card_ready, 1'b1);
    n = 0;
    while (fifo_busy && n < 100) begin tick(1); n++; end
    check("init_fb_len", n, 32'd24);
    tick(1);
    check("init_done", done, 1'b1);
    check("init_done_busy", busy, 1'b0);
    check("init_err", err, 1'b0);
    init_ok = 1'b0;
    tick(5);

    // Read 3 sectors from 0x1000; a wr_req pulsed while busy must be ignored
    d0 = done_cnt;
    exp_q.push_back(32'h0000_1000);
    exp_q.push_back(32'h0000_1001);
    exp_q.push_back(32'h0000_1002);
    rd_req = 1'b1; req_sec = 32'h0000_1000; req_cnt = 16'd3;
    tick(1);
    rd_req = 1'b0;
    check("rd_issue_busy", busy, 1'b1);
    check("rd_issue_no_ren", sd_ren, 1'b0);
    tick(1);
    check("rd_ren", sd_ren, 1'b1);
    check("rd_sec0", sec, 32'h0000_1000);
    serve(1'b1, "rd_s0");
    wr_req = 1'b1; req_sec = 32'h5555; req_cnt = 16'd1;
    tick(1);
    wr_req = 1'b0;
    serve(1'b1, "rd_s1");
    serve(1'b1, "rd_s2");
    wait_done("rd_done");
    check("rd_sectors_done", sectors_done, 16'd3);
    check("rd_err", err, 1'b0);
    tick(50);
    check("rd_one_done", done_cnt - d0, 32'd1);
    check("ignore_no_write", wen_rises, 0);
    check("ignore_idle", busy, 1'b0);
    check_secs("rd");

    // Write 2 sectors across the 32-bit address wrap
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_0000);
    wr_req = 1'b1; req_sec = 32'hFFFF_FFFF; req_cnt = 16'd2;
    tick(1);
    wr_req = 1'b0;
    serve(1'b0, "wr_s0");
    serve(1'b0, "wr_s1");
    wait_done("wr_done");
    check("wr_sectors_done", sectors_done, 16'd2);
    check("wr_err", err, 1'b0);
    check_secs("wr");
    tick(3);

    // Zero count after init: immediate completion, no engine activity
    r0 = ren_rises; w0 = wen_rises;
    rd_req = 1'b1; req_sec = 32'h77; req_cnt = 16'd0;
    tick(2);
    rd_req = 1'b0;
    check("zero_done", done, 1'b1);
    check("zero_err", err, 1'b0);
    check("zero_no_engine", (ren_rises - r0) + (wen_rises - w0), 32'd0);
    tick(3);

    // Priority: all three requests at once -> only init runs
    r0 = ren_rises; w0 = wen_rises; i0 = init_rises;
    start_init = 1'b1; rd_req = 1'b1; wr_req = 1'b1; req_cnt = 16'd1;
    tick(1);
    start_init = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    check("prio_sd_init", sd_init, 1'b1);
    check("prio_no_ren_wen", {sd_ren, sd_wen}, 2'b00);
    check("prio_card_ready_cleared", card_ready, 1'b0);
    tick(20);
    init_ok = 1'b1;
    wait_done("prio_done");
    init_ok = 1'b0;
    check("prio_card_ready", card_ready, 1'b1);
    check("prio_only_init", {ren_rises - r0, wen_rises - w0, init_rises - i0}, {32'd0, 32'd0, 32'd1});
    tick(5);

    // Timeout: rd_ok never rises
    rd_req = 1'b1; req_sec = 32'h200; req_cnt = 16'd1;
    tick(2);
    rd_req = 1'b0;
    check("tmo_ren", sd_ren, 1'b1);
    n = 0;
    while (sd_ren && n < 2000) begin tick(1); n++; end
    check("tmo_ren_len", n, 32'd1000);
    check("tmo_err", err, 1'b1);
    n = 0;
    while (fifo_busy && n < 100) begin tick(1); n++; end
    check("tmo_fb_len", n, 32'd24);
    tick(1);
    check("tmo_done", done, 1'b1);
    check("tmo_sectors_done", sectors_done, 16'd0);
    check("tmo_err_sticky", err, 1'b1);
    tick(3);

    // Asynchronous reset in the middle of WAIT
    rd_req = 1'b1; req_sec = 32'h300; req_cnt = 16'd2;
    tick(1);
    rd_req = 1'b0;
    tick(3);
    check("arst_pre_ren", sd_ren, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_outputs", {busy, done, err, card_ready, sd_init, sd_ren, sd_wen, fifo_busy}, 8'd0);
    check("arst_sec", sec, 32'd0);
    check("arst_sectors_done", sectors_done, 16'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    check("never_fb_with_req", overlap_cnt, 0);
    check("never_two_reqs", multi_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
